// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: controller state encoding and default width.
package serial_adder_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// Single-bit full adder; the only arithmetic element used by the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full adder, LSB-first shifting, WIDTH cycles per add.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_co;

  full_adder u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ADD;
      ADD:     if (cnt == CW'(WIDTH - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == ADD);

  // Sum bits enter at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      sum_sr    <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      done      <= 1'b0;
      sum_out   <= '0;
      carry_out <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          a_sr   <= a_in;
          b_sr   <= b_in;
          carry  <= c_in;
          sum_sr <= '0;
          cnt    <= '0;
        end
        ADD: begin
          sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= fa_co;
          cnt    <= cnt + CW'(1);
        end
        DONE: begin
          sum_out   <= sum_sr;
          carry_out <= carry;
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: driver pushes expected results, negedge monitor checks them.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a_in  = '0;
  logic [W-1:0] b_in  = '0;
  logic         c_in  = 1'b0;
  logic         busy, done, carry_out;
  logic [W-1:0] sum_out;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .a_in      (a_in),
    .b_in      (b_in),
    .c_in      (c_in),
    .busy      (busy),
    .done      (done),
    .sum_out   (sum_out),
    .carry_out (carry_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] sum;
    logic         carry;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   cyc      = 0;
  int   done_cnt = 0;
  int   n_cmp    = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial forever begin
    @(negedge clock);
    if (!reset && done) begin
      done_cnt++;
      if (q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 with no pending add, expected done=0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sum_out", 32'(sum_out), 32'(e.sum));
        check("carry_out", 32'(carry_out), 32'(e.carry));
        check("done_latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Start accepted at edge cyc+1; done visible after edge cyc+1+W+1.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic [W-1:0] es, input logic ec);
    exp_t e;
    e.sum = es; e.carry = ec; e.cyc = cyc + W + 2;
    q.push_back(e);
    start = 1'b1; a_in = a; b_in = b; c_in = c;
    @(negedge clock);
    start = 1'b0;
    a_in = ~a; b_in = a ^ b; c_in = ~c;
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) seen = 1;
      else @(negedge clock);
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got no done within 40 cycles, expected a done pulse", name);
    end
  endtask

  initial begin
    int base, d0, e0;
    repeat (3) @(negedge clock);
    check("rst_sum_out", 32'(sum_out), 32'h0);
    check("rst_carry_out", 32'(carry_out), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    reset = 1'b0;

    // Directed vectors with hand-computed results.
    issue(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0);
    check("busy_in_add", 32'(busy), 32'h1);
    wait_done("v1");
    issue(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    wait_done("v2");
    issue(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    wait_done("v3");
    repeat (3) @(negedge clock);
    check("hold_sum_out", 32'(sum_out), 32'hFF);
    check("hold_carry_out", 32'(carry_out), 32'h1);

    // Start re-pulsed mid-ADD must be ignored.
    d0 = done_cnt;
    issue(8'h10, 8'h20, 1'b0, 8'h30, 1'b0);
    repeat (3) @(negedge clock);
    start = 1'b1; a_in = 8'h01;
    @(negedge clock);
    start = 1'b0;
    wait_done("v4");
    repeat (14) @(negedge clock);
    #1;
    check("ignored_start_done_count", 32'(done_cnt - d0), 32'd1);

    // Reset in the 4th ADD cycle aborts with no done.
    start = 1'b1; a_in = 8'h77; b_in = 8'h11; c_in = 1'b0;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    #1;
    check("abort_sum_out", 32'(sum_out), 32'h0);
    check("abort_carry_out", 32'(carry_out), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    d0 = done_cnt;
    @(negedge clock);
    reset = 1'b0;
    repeat (14) @(negedge clock);
    #1;
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    issue(8'h02, 8'h03, 1'b0, 8'h05, 1'b0);
    wait_done("v5");

    // start held high for 30 cycles: accepted at e0, e0+10, e0+20.
    base = cyc;
    e0 = base + 1;
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      e.sum = 8'h8D; e.carry = 1'b0; e.cyc = e0 + 10 * k + W + 1;
      q.push_back(e);
    end
    start = 1'b1; a_in = 8'h5A; b_in = 8'h33; c_in = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      check("held_busy", 32'(busy), ((cyc - e0) % 10) <= 7 ? 32'd1 : 32'd0);
    end
    start = 1'b0;
    repeat (14) @(negedge clock);
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to add; sampled only in IDLE.
REQ-005 a_in  input  WIDTH  operand A; captured on accepted start.
REQ-006 b_in  input  WIDTH  operand B; captured on accepted start.
REQ-007 c_in  input  1  carry-in; captured on accepted start.
REQ-008 busy  output  1  high while an addition is in progress (state ADD).
REQ-009 done  output  1  single-cycle pulse, result valid.
REQ-010 sum_out  output  WIDTH  result sum; holds its value until the next accepted start.
REQ-011 carry_out  output  1  result carry; holds its value until the next accepted start.
REQ-012 The block SHALL have one clock; reset SHALL be asynchronous and active-high.

Function
REQ-013 The FSM SHALL have 3 states: IDLE, ADD, DONE.
- IDLE->ADD on start=1.
- ADD->DONE after WIDTH bit-cycles.
- DONE->IDLE unconditionally.
REQ-014 Accepted start (IDLE, start=1) SHALL load:
- a_in and b_in into shift registers;
- c_in into the carry flop;
- bit counter to 0.
REQ-015 Each ADD cycle SHALL add the LSBs of the A and B shift registers plus the carry flop through the full adder, then:
- shift the sum bit into the MSB of the sum register;
- shift A and B right by one;
- store carry-out into the carry flop;
- increment the counter.
REQ-016 After exactly WIDTH ADD cycles, the sum register SHALL hold bit 0 at its LSB; this is the full result, with no reordering step.
REQ-017 Latency: with start sampled at edge N, done SHALL be high in the cycle following edge N+WIDTH+1 and SHALL pulse for exactly one cycle.
REQ-018 carry_out SHALL update from the carry flop on the DONE transition; sum_out and carry_out SHALL be stable from done until the next accepted start.
REQ-019 start in ADD or DONE SHALL be ignored, with no queuing; operands changing during ADD SHALL have no effect.
REQ-020 start held high continuously SHALL begin a new addition on each IDLE visit, giving a period of WIDTH+2 cycles.
REQ-021 busy SHALL equal 1 exactly when the state is ADD.
REQ-022 The counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL never wrap within one operation.
REQ-023 Arithmetic SHALL be unsigned modulo 2^WIDTH, with the overflow bit in carry_out.

Reset
REQ-024 Reset SHALL drive the following to zero: state to IDLE, busy, done, sum_out, carry_out, shift registers, carry flop and counter.
REQ-025 Reset asserted mid-ADD SHALL abort the operation immediately; no done pulse SHALL follow.
REQ-026 After reset deasserts, the first start SHALL be accepted on the next rising edge.

Structure
REQ-027 The FSM state encoding (IDLE, ADD, DONE) and the WIDTH default SHALL live in the shared package serial_adder_pkg.
REQ-028 The block SHALL instantiate exactly one existing full_adder sub-module as its only bit-level adder; it SHALL NOT use a behavioural "+".
REQ-029 The controller SHALL be a single always block for state and datapath registers, plus a combinational next-state block.

Verification
REQ-030 The bench SHALL cover these directed scenarios (WIDTH=8):
- a=0x5A, b=0x33, c_in=0 -> sum_out=0x8D, carry_out=0, done 10 cycles after start edge.
- a=0xFF, b=0x01, c_in=0 -> sum_out=0x00, carry_out=1 (full carry ripple).
- a=0xFF, b=0xFF, c_in=1 -> sum_out=0xFF, carry_out=1.
- start re-pulsed with a=0x01 during ADD of 0x10+0x20 -> ignored; result 0x30, carry 0; exactly one done pulse.
- reset asserted at cycle 4 of ADD -> all outputs 0 immediately, no done; next start 0x02+0x03 -> 0x05.
- start held high for 30 cycles -> done every 10 cycles, busy low only in IDLE and DONE.
